lram_port_sequencer: RTL and testbench

//  Sequences one LIFCL LRAM_CORE port (16K x 32, ECC_BYTE_SEL=BYTE_EN) shared by two requesters.

---
 rtl/lram_seq_pkg.sv | 28 ++
 rtl/lram_port_sequencer_if.sv | 31 +++
 rtl/lram_rr_arb2.sv | 33 +++
 rtl/lram_port_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_lram_port_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lram_seq_pkg.sv
// Shared types and constants for the LRAM port sequencer.
// Holds the sequencer state encoding and the fill-pattern rule.
package lram_seq_pkg;

    typedef enum logic {
        S_FILL = 1'b0,
        S_RUN  = 1'b1
    } seq_state_e;

    localparam int LRAM_DEPTH = 16384;
    localparam int LRAM_DW    = 32;
    localparam int LRAM_BW    = LRAM_DW / 8;

    // Mode 1 stamps each word with its own address so a misrouted fill is visible.
    function automatic logic [LRAM_DW-1:0] fill_word(
        input logic [LRAM_DW-1:0] addr_ext,
        input int                 mode,
        input logic [LRAM_DW-1:0] init_word
    );
        logic [LRAM_DW-1:0] w_word;
        w_word = init_word;
        if (mode == 1) begin
            w_word = init_word ^ addr_ext;
        end
        return w_word;
    endfunction

endpackage

// File: rtl/lram_port_sequencer_if.sv
// Requester-side bus of the LRAM port sequencer: two command channels in,
// grant and shared read-return out.
interface lram_port_sequencer_if #(
    parameter int AW = 14,
    parameter int DW = 32
);
    localparam int BW = DW / 8;

    // Handshake: a requester raises req[i] with we/addr/wdata/be and holds them
    // stable until gnt[i] is high in the same cycle; that cycle consumes exactly
    // one command. Reads return later as a one-cycle rvalid[i] with rdata.
    logic [1:0]      req;
    logic [1:0]      we;
    logic [2*AW-1:0] addr;
    logic [2*DW-1:0] wdata;
    logic [2*BW-1:0] be;
    logic [1:0]      gnt;
    logic [1:0]      rvalid;
    logic [DW-1:0]   rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/lram_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, pointer flips to the
// other requester after every grant.
module lram_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    logic r_rr_ptr;
    logic [1:0] w_gnt;

    always_comb begin
        w_gnt = 2'b00;
        case (i_req)
            2'b01:   w_gnt = 2'b01;
            2'b10:   w_gnt = 2'b10;
            2'b11:   w_gnt = r_rr_ptr ? 2'b10 : 2'b01;
            default: w_gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= 1'b0;
        end else if (w_gnt != 2'b00) begin
            r_rr_ptr <= ~w_gnt[1];
        end
    end

    assign o_gnt = w_gnt;

endmodule

// File: rtl/lram_port_sequencer.sv
// Sequences one LRAM port: a full fill pass after reset, then round-robin
// service of two requesters with read data routed back by issuing id.
module lram_port_sequencer
    import lram_seq_pkg::*;
#(
    parameter int             DEPTH     = LRAM_DEPTH,
    parameter int             DW        = LRAM_DW,
    parameter int             READ_LAT  = 2,
    parameter int             INIT_MODE = 0,
    parameter logic [DW-1:0]  INIT_WORD = '0,
    localparam int            AW        = $clog2(DEPTH),
    localparam int            BW        = DW / 8
) (
    input  logic                 clk,
    input  logic                 rst,
    lram_port_sequencer_if.slave bus,
    output logic                 init_done,
    output logic                 mem_cs,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    output logic [BW-1:0]        mem_be,
    input  logic [DW-1:0]        mem_rdata,
    output seq_state_e           o_dbg_st
);

    localparam logic [AW:0] CNT_END = (AW+1)'(DEPTH);

    seq_state_e r_st;
    seq_state_e w_st_nxt;
    logic       w_fill_en;
    logic       w_run;
    logic       w_fill_last;

    logic [AW:0]   r_cnt;
    logic          r_init_done;
    logic [DW-1:0] w_fill_word;

    logic [1:0]    w_arb_req;
    logic [1:0]    w_gnt;
    logic          w_gnt_id;
    logic          w_sel_we;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;
    logic [BW-1:0] w_sel_be;

    logic          r_mem_cs;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic [BW-1:0] r_mem_be;
    logic          r_issue_id;

    logic [READ_LAT-1:0] r_pipe_vld;
    logic [READ_LAT-1:0] r_pipe_id;
    logic [1:0]          r_rvalid;
    logic [DW-1:0]       r_rdata;

    // ---------------- FSM ----------------
    assign w_fill_last = (r_cnt == CNT_END);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_st <= S_FILL;
        end else begin
            r_st <= w_st_nxt;
        end
    end

    always_comb begin
        w_st_nxt  = r_st;
        w_fill_en = 1'b0;
        w_run     = 1'b0;
        case (r_st)
            S_FILL: begin
                if (w_fill_last) begin
                    w_st_nxt = S_RUN;
                end else begin
                    w_fill_en = 1'b1;
                end
            end
            S_RUN: begin
                w_run = 1'b1;
            end
            default: begin
                w_st_nxt = S_FILL;
            end
        endcase
    end

    // The counter runs one past the last address so the state change lands
    // the cycle after the final fill write is on the pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_init_done <= 1'b0;
        end else begin
            if (w_fill_en) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_st_nxt == S_RUN) begin
                r_init_done <= 1'b1;
            end
        end
    end

    assign w_fill_word = DW'(fill_word(32'(r_cnt[AW-1:0]), INIT_MODE, 32'(INIT_WORD)));

    // ---------------- Arbitration ----------------
    assign w_arb_req = w_run ? bus.req : 2'b00;

    lram_rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .i_req (w_arb_req),
        .o_gnt (w_gnt)
    );

    assign w_gnt_id    = w_gnt[1];
    assign w_sel_we    = w_gnt_id ? bus.we[1] : bus.we[0];
    assign w_sel_addr  = w_gnt_id ? bus.addr[2*AW-1:AW] : bus.addr[AW-1:0];
    assign w_sel_wdata = w_gnt_id ? bus.wdata[2*DW-1:DW] : bus.wdata[DW-1:0];
    assign w_sel_be    = w_gnt_id ? bus.be[2*BW-1:BW] : bus.be[BW-1:0];

    // ---------------- Issue registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_cs    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
            r_issue_id  <= 1'b0;
        end else if (w_fill_en) begin
            r_mem_cs    <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_cnt[AW-1:0];
            r_mem_wdata <= w_fill_word;
            r_mem_be    <= '1;
        end else if (w_gnt != 2'b00) begin
            r_mem_cs    <= 1'b1;
            r_mem_we    <= w_sel_we;
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
            r_mem_be    <= w_sel_be;
            r_issue_id  <= w_gnt_id;
        end else begin
            r_mem_cs <= 1'b0;
            r_mem_we <= 1'b0;
        end
    end

    // ---------------- Read return ----------------
    // Stage k holds the read issued k+1 cycles ago; the last stage lines up
    // with mem_rdata being valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe_vld <= '0;
            r_pipe_id  <= '0;
        end else begin
            r_pipe_vld[0] <= r_mem_cs & ~r_mem_we;
            r_pipe_id[0]  <= r_issue_id;
            for (int k = 1; k < READ_LAT; k++) begin
                r_pipe_vld[k] <= r_pipe_vld[k-1];
                r_pipe_id[k]  <= r_pipe_id[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rvalid <= 2'b00;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= 2'b00;
            if (r_pipe_vld[READ_LAT-1]) begin
                r_rvalid <= r_pipe_id[READ_LAT-1] ? 2'b10 : 2'b01;
                r_rdata  <= mem_rdata;
            end
        end
    end

    // ---------------- Outputs ----------------
    assign bus.gnt    = w_gnt;
    assign bus.rvalid = r_rvalid;
    assign bus.rdata  = r_rdata;
    assign init_done  = r_init_done;
    assign mem_cs     = r_mem_cs;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_be     = r_mem_be;
    assign o_dbg_st   = r_st;

endmodule

// File: tb/tb_lram_port_sequencer.sv
// Bench for lram_port_sequencer: LRAM behavioural stand-in, a spec-level
// reference model compared every cycle, and directed plus random traffic.
module tb_lram_port_sequencer;
    import lram_seq_pkg::*;

    localparam int            DEPTH     = 16;
    localparam int            AW        = 4;
    localparam int            DW        = 32;
    localparam int            BW        = 4;
    localparam int            READ_LAT  = 2;
    localparam int            INIT_MODE = 1;
    localparam logic [DW-1:0] INIT_WORD = 32'hA5A50000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tb_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    lram_port_sequencer_if #(.AW(AW), .DW(DW)) bus ();

    logic          init_done;
    logic          mem_cs;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [BW-1:0] mem_be;
    logic [DW-1:0] mem_rdata;
    seq_state_e    dbg_st;

    lram_port_sequencer #(
        .DEPTH     (DEPTH),
        .DW        (DW),
        .READ_LAT  (READ_LAT),
        .INIT_MODE (INIT_MODE),
        .INIT_WORD (INIT_WORD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .init_done (init_done),
        .mem_cs    (mem_cs),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_rdata (mem_rdata),
        .o_dbg_st  (dbg_st)
    );

    // ---------------- LRAM stand-in ----------------
    logic [DW-1:0] lram [DEPTH];
    logic [DW-1:0] lram_q [READ_LAT];
    logic [DW-1:0] lram_wtmp;

    always @(posedge clk) begin
        if (mem_cs && mem_we) begin
            lram_wtmp = lram[mem_addr];
            for (int b = 0; b < BW; b++) begin
                if (mem_be[b]) lram_wtmp[b*8 +: 8] = mem_wdata[b*8 +: 8];
            end
            lram[mem_addr] <= lram_wtmp;
        end
        lram_q[0] <= (mem_cs && !mem_we) ? lram[mem_addr] : '0;
        for (int k = 1; k < READ_LAT; k++) lram_q[k] <= lram_q[k-1];
    end
    assign mem_rdata = lram_q[READ_LAT-1];

    // ---------------- scoreboard ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s tb_cyc=%0d actual=%0h expected=%0h", name, tb_cyc, act, exp);
        end
    endtask

    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
    } rd_t;

    rd_t           exp_q[$];
    logic [DW-1:0] ref_mem [DEPTH];
    bit            m_rst_seen = 0;
    bit            m_active   = 0;
    int            m_cyc      = 0;
    bit            m_rr;
    bit            prev_any, prev_we;
    logic [AW-1:0] prev_addr, last_addr;
    logic [DW-1:0] prev_wdata, last_wdata;
    logic [BW-1:0] prev_be, last_be;
    logic [1:0]    e_gnt, e_rv;
    logic          e_done, e_cs, e_we;
    logic [DW-1:0] e_rd, c_wd, c_mask;
    logic [AW-1:0] c_addr;
    logic [BW-1:0] c_be;
    int            c_id;

    // Model: m_cyc counts cycles from reset release (cycle 0); fill writes occupy
    // cycles 1..DEPTH, arbitration starts at DEPTH+1, reads return gnt+READ_LAT+2.
    always @(negedge clk) begin
        if (rst) begin
            m_rst_seen = 1;
            exp_q.delete();
        end else if (m_rst_seen || m_active) begin
            if (m_rst_seen) begin
                m_cyc = 0; m_rst_seen = 0; m_active = 1; m_rr = 0; prev_any = 0;
                last_addr = '0; last_wdata = '0; last_be = '0;
                for (int i = 0; i < DEPTH; i++) ref_mem[i] = INIT_WORD ^ DW'(i);
            end else begin
                m_cyc++;
            end
            e_done = (m_cyc >= DEPTH + 1);
            e_gnt  = 2'b00;
            if (e_done) e_gnt = (bus.req == 2'b11) ? (m_rr ? 2'b10 : 2'b01) : bus.req;
            if (m_cyc >= 1 && m_cyc <= DEPTH) begin
                e_cs = 1; e_we = 1;
                last_addr  = AW'(m_cyc - 1);
                last_wdata = INIT_WORD ^ DW'(m_cyc - 1);
                last_be    = '1;
            end else if (prev_any) begin
                e_cs = 1; e_we = prev_we;
                last_addr = prev_addr; last_wdata = prev_wdata; last_be = prev_be;
            end else begin
                e_cs = 0; e_we = 0;
            end
            e_rv = 2'b00; e_rd = '0;
            if (exp_q.size() > 0 && exp_q[0].due == m_cyc) begin
                e_rv = (exp_q[0].id == 1) ? 2'b10 : 2'b01;
                e_rd = exp_q[0].data;
                void'(exp_q.pop_front());
            end
            chk("gnt", bus.gnt, e_gnt);
            chk("rvalid", bus.rvalid, e_rv);
            if (e_rv != 2'b00 || m_cyc == 0) chk("rdata", bus.rdata, e_rd);
            chk("init_done", init_done, e_done);
            chk("state", dbg_st, e_done ? S_RUN : S_FILL);
            chk("mem_cs", mem_cs, e_cs);
            chk("mem_we", mem_we, e_we);
            chk("mem_addr", mem_addr, last_addr);
            chk("mem_wdata", mem_wdata, last_wdata);
            chk("mem_be", mem_be, last_be);
            if (e_gnt != 2'b00) begin
                c_id   = e_gnt[1] ? 1 : 0;
                m_rr   = (c_id == 0);
                c_addr = c_id ? bus.addr[2*AW-1:AW] : bus.addr[AW-1:0];
                c_wd   = c_id ? bus.wdata[2*DW-1:DW] : bus.wdata[DW-1:0];
                c_be   = c_id ? bus.be[2*BW-1:BW] : bus.be[BW-1:0];
                prev_any = 1; prev_we = bus.we[c_id];
                prev_addr = c_addr; prev_wdata = c_wd; prev_be = c_be;
                if (prev_we) begin
                    c_mask = '0;
                    for (int b = 0; b < BW; b++) if (c_be[b]) c_mask[b*8 +: 8] = 8'hFF;
                    ref_mem[c_addr] = (ref_mem[c_addr] & ~c_mask) | (c_wd & c_mask);
                end else begin
                    exp_q.push_back('{due: m_cyc + READ_LAT + 2, id: c_id, data: ref_mem[c_addr]});
                end
            end else begin
                prev_any = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [1:0] en, input logic [1:0] w,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                         input logic [BW-1:0] b0, input logic [BW-1:0] b1,
                         output int g0, output int g1);
        logic [1:0] gs;
        int n;
        bus.req = en; bus.we = w; bus.addr = {a1, a0};
        bus.wdata = {d1, d0}; bus.be = {b1, b0};
        g0 = -1; g1 = -1; n = 0;
        while (bus.req != 2'b00 && n < 40) begin
            @(negedge clk);
            n++;
            gs = bus.gnt;
            if (gs[0]) g0 = tb_cyc;
            if (gs[1]) g1 = tb_cyc;
            @(posedge clk); #1;
            bus.req = bus.req & ~gs;
        end
        if (bus.req != 2'b00) begin
            chk("gnt_timeout", bus.req, 2'b00);
            bus.req = 2'b00;
        end
    endtask

    task automatic wait_rv(input int id, output int cyc, output logic [DW-1:0] d);
        int n;
        n = 0; cyc = -1; d = '0;
        while (cyc < 0 && n < 20) begin
            @(negedge clk);
            n++;
            if (bus.rvalid[id]) begin
                cyc = tb_cyc;
                d   = bus.rdata;
            end
        end
        if (cyc < 0) chk("rvalid_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        bus.req = 2'b00;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    int            n, g0, g1, rc0, rc1;
    logic [DW-1:0] rd0, rd1;
    logic [1:0]    fill_gnt, rv_seen, gs;
    logic [1:0]    gsq [4];

    initial begin
        bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0; bus.be = '0;
        for (int i = 0; i < DEPTH; i++) lram[i] = '0;
        for (int k = 0; k < READ_LAT; k++) lram_q[k] = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Both requesters held through the fill, then strict alternation.
        bus.req = 2'b11; bus.we = 2'b00; bus.addr = {4'd9, 4'd7};
        n = -1; fill_gnt = 2'b00;
        do begin
            @(negedge clk);
            n++;
            if (!init_done) fill_gnt = fill_gnt | bus.gnt;
        end while (!init_done && n < 40);
        chk("init_done_cycle", n, 17);
        chk("gnt_during_fill", fill_gnt, 2'b00);
        gsq[0] = bus.gnt;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            gsq[k] = bus.gnt;
        end
        @(posedge clk); #1;
        bus.req = 2'b00;
        chk("gnt_sequence", {gsq[0], gsq[1], gsq[2], gsq[3]}, 8'b01_10_01_10);
        idle(6);

        drive(2'b01, 2'b00, 4'd5, 4'd0, '0, '0, '0, '0, g0, g1);
        wait_rv(0, rc0, rd0);
        chk("rd5_latency", rc0 - g0, 4);
        chk("rd5_data", rd0, 32'hA5A50005);
        idle(3);

        drive(2'b10, 2'b10, 4'd0, 4'd3, '0, 32'h1234_5678, '0, 4'b0011, g0, g1);
        drive(2'b10, 2'b00, 4'd0, 4'd3, '0, '0, '0, '0, g0, g1);
        wait_rv(1, rc1, rd1);
        chk("rd3_merged_data", rd1, 32'hA5A55678);
        idle(3);

        drive(2'b11, 2'b00, 4'd1, 4'd2, '0, '0, '0, '0, g0, g1);
        chk("pair_gnt_spacing", g1 - g0, 1);
        wait_rv(0, rc0, rd0);
        wait_rv(1, rc1, rd1);
        chk("pair_rd1_data", rd0, 32'hA5A50001);
        chk("pair_rd2_data", rd1, 32'hA5A50002);
        chk("pair_rv_spacing", rc1 - rc0, 1);
        idle(3);

        // Random traffic: each requester holds its command until granted.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!bus.req[i] && $urandom_range(0, 3) != 0) begin
                    bus.req[i] = 1'b1;
                    bus.we[i]  = 1'($urandom_range(0, 1));
                    bus.addr[i*AW +: AW]  = AW'($urandom_range(0, DEPTH - 1));
                    bus.wdata[i*DW +: DW] = $urandom;
                    bus.be[i*BW +: BW]    = BW'($urandom_range(0, 15));
                end
            end
            @(negedge clk);
            gs = bus.gnt;
            @(posedge clk); #1;
            bus.req = bus.req & ~gs;
        end
        idle(10);

        // Reset with two reads in flight.
        drive(2'b11, 2'b00, AW'($urandom_range(0, DEPTH - 1)), AW'($urandom_range(0, DEPTH - 1)),
              '0, '0, '0, '0, g0, g1);
        rst = 1'b1;
        rv_seen = 2'b00;
        repeat (2) begin
            @(negedge clk);
            if (tb_cyc > g1 + 2) rv_seen = rv_seen | bus.rvalid;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        n = -1;
        do begin
            @(negedge clk);
            n++;
            rv_seen = rv_seen | bus.rvalid;
            if (n == 0) chk("rst_init_done_low", init_done, 1'b0);
            if (n == 1) begin
                chk("refill_cs", mem_cs, 1'b1);
                chk("refill_addr0", mem_addr, 4'd0);
            end
        end while (!init_done && n < 40);
        chk("no_rvalid_after_rst", rv_seen, 2'b00);
        chk("refill_done_cycle", n, 17);
        @(posedge clk); #1;

        drive(2'b01, 2'b00, 4'd4, 4'd0, '0, '0, '0, '0, g0, g1);
        wait_rv(0, rc0, rd0);
        chk("post_rst_rd4", rd0, 32'hA5A50004);
        drive(2'b10, 2'b00, 4'd0, 4'd3, '0, '0, '0, '0, g0, g1);
        wait_rv(1, rc1, rd1);
        chk("post_rst_rd3", rd1, 32'hA5A50003);
        idle(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog tb_cyc=%0d actual=running expected=finished", tb_cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
